// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared CPU constants: major opcodes, the bubble instruction
//           word, and the RUN/STALL state encoding of the IF/ID stall
//           controller.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  // Bubble word. Opcode 111111 matches no writer opcode, so a bubble can never
  // look like a register writer to the downstream hazard compare. An all-zero
  // word would decode as an R-type write to r0, so it is not used.
  localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'd0};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_state_t;

endpackage
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : stall_watchdog
// Purpose : Saturating consecutive-stall counter with a sticky error flag.
//           The flag is set on the stall edge that takes the count past
//           MAX_STALL, and only rst clears it.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           stall_now      - the pipeline holds this cycle
//           clear          - restart the count (stall run ended)
//           stall_err      - sticky watchdog flag
// Rev     : 1.0  initial release
// ============================================================================
module stall_watchdog #(
  parameter int MAX_STALL = 7,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_now,
  input  logic clear,
  output logic stall_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_TRIP = CNT_W'(MAX_STALL);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (stall_now) begin
      r_cnt <= (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      // This edge moves the count to MAX_STALL+1. Comparing the current
      // value keeps the check valid when MAX_STALL+1 equals 2^CNT_W.
      if (r_cnt == C_CNT_TRIP) begin
        r_err <= 1'b1;
      end
    end else if (clear) begin
      r_cnt <= '0;
    end
  end

  assign stall_err = r_err;

endmodule
`default_nettype wire

// File: rtl/if_id_stall_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_stall_reg
// Purpose : IF/ID pipeline register with hazard-driven stall control. It
//           holds the step-2 instruction and decodes the fields used by the
//           hazard detector. It also consumes is_hazard in the same cycle to
//           freeze the PC and this register and to request an ID/EX bubble.
//           A watchdog flags a stall run longer than MAX_STALL cycles.
// Ports   : clk, rst (sync, active high); instr_in, pc_plus4_in, is_hazard,
//           flush inputs; instr_step_2, pc_plus4_step_2, opcode_step_2, rs,
//           rt, rd, valid_step_2, pc_we, bubble_step_3, stall_err outputs.
// Option  : IF_ID_STALL_PERF_EN adds perf_stall_cycles / perf_hazard_events.
// Rev     : 1.0  initial release
// ============================================================================
module if_id_stall_reg
  import cpu_pkg::*;
#(
  parameter int MAX_STALL = 7,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        is_hazard,
  input  logic        flush,
  output logic [31:0] instr_step_2,
  output logic [31:0] pc_plus4_step_2,
  output logic [5:0]  opcode_step_2,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        valid_step_2,
  output logic        pc_we,
  output logic        bubble_step_3,
`ifdef IF_ID_STALL_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_hazard_events,
`endif
  output logic        stall_err
);

  logic [31:0]  r_instr;
  logic [31:0]  r_pc_plus4;
  logic         r_valid;
  stall_state_t r_state;
  stall_state_t w_state_next;
  logic         w_stall_now;

  // A hazard only matters for a real instruction, and a redirect takes
  // priority because the flushed instruction will never issue.
  assign w_stall_now   = is_hazard & r_valid & ~flush;
  assign pc_we         = ~w_stall_now;
  assign bubble_step_3 = w_stall_now | flush | ~r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_RUN;
    if (!flush && w_stall_now) begin
      w_state_next = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (flush) begin
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end else if (!w_stall_now) begin
      r_instr    <= instr_in;
      r_pc_plus4 <= pc_plus4_in;
      r_valid    <= 1'b1;
    end
  end

  assign instr_step_2    = r_instr;
  assign pc_plus4_step_2 = r_pc_plus4;
  assign valid_step_2    = r_valid;
  assign opcode_step_2   = r_instr[31:26];
  assign rs              = r_instr[25:21];
  assign rt              = r_instr[20:16];
  assign rd              = r_instr[15:11];

  stall_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .stall_now (w_stall_now),
    .clear     (~w_stall_now),
    .stall_err (stall_err)
  );

`ifdef IF_ID_STALL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall  <= 32'd0;
      r_perf_events <= 32'd0;
    end else begin
      if (w_stall_now) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (r_state == ST_RUN && w_state_next == ST_STALL) begin
        r_perf_events <= r_perf_events + 32'd1;
      end
    end
  end

  assign perf_stall_cycles  = r_perf_stall;
  assign perf_hazard_events = r_perf_events;
`else
  // Without the perf counters nothing reads the state register.
  logic w_state_unused;
  assign w_state_unused = r_state[0] ^ w_state_next[0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stall_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_id_stall_reg
// Purpose : Self-checking bench for if_id_stall_reg. A behavioural model
//           pushes the expected register state per step into a queue. The
//           entry is popped and compared one edge later. Combinational
//           outputs are compared inside each cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_if_id_stall_reg;
  import cpu_pkg::*;

  localparam int MAX_STALL = 7;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = 32'd0;
  logic [31:0] pc_plus4_in = 32'd0;
  logic        is_hazard = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_step_2;
  logic [31:0] pc_plus4_step_2;
  logic [5:0]  opcode_step_2;
  logic [4:0]  rs, rt, rd;
  logic        valid_step_2, pc_we, bubble_step_3, stall_err;
`ifdef IF_ID_STALL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_hazard_events;
`endif

  if_id_stall_reg #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_in           (instr_in),
    .pc_plus4_in        (pc_plus4_in),
    .is_hazard          (is_hazard),
    .flush              (flush),
    .instr_step_2       (instr_step_2),
    .pc_plus4_step_2    (pc_plus4_step_2),
    .opcode_step_2      (opcode_step_2),
    .rs                 (rs),
    .rt                 (rt),
    .rd                 (rd),
    .valid_step_2       (valid_step_2),
    .pc_we              (pc_we),
    .bubble_step_3      (bubble_step_3),
`ifdef IF_ID_STALL_PERF_EN
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_hazard_events (perf_hazard_events),
`endif
    .stall_err          (stall_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        err;
    logic        chk_pc;
    logic [31:0] ps;
    logic [31:0] he;
  } exp_t;

  exp_t q[$];

  // reference model state
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_err;
  logic        m_in_stall;
  int          m_cnt;
  logic [31:0] m_ps, m_he;
  bit          m_known = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic hz, input logic fl);
    logic stall;
    exp_t e;
    rst = r; instr_in = ins; pc_plus4_in = pc; is_hazard = hz; flush = fl;
    #1;
    stall = m_known && hz && m_valid && !fl;
    if (m_known) begin
      chk("pc_we", {31'd0, pc_we}, {31'd0, ~stall});
      chk("bubble", {31'd0, bubble_step_3}, {31'd0, stall | fl | ~m_valid});
    end
    e.chk_pc = 1'b1;
    if (r) begin
      m_instr = NOP_INSTR; m_pc = 32'd0; m_valid = 1'b0;
      m_cnt = 0; m_err = 1'b0; m_ps = 32'd0; m_he = 32'd0; m_in_stall = 1'b0;
      m_known = 1'b1;
    end else if (fl) begin
      m_instr = NOP_INSTR; m_valid = 1'b0; m_cnt = 0; m_in_stall = 1'b0;
      e.chk_pc = 1'b0;
    end else if (stall) begin
      if (m_cnt == MAX_STALL) m_err = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
      m_ps = m_ps + 32'd1;
      if (!m_in_stall) m_he = m_he + 32'd1;
      m_in_stall = 1'b1;
    end else begin
      m_instr = ins; m_pc = pc; m_valid = 1'b1; m_cnt = 0; m_in_stall = 1'b0;
    end
    e.instr = m_instr; e.pc = m_pc; e.valid = m_valid; e.err = m_err;
    e.ps = m_ps; e.he = m_he;
    q.push_back(e);

    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("instr", instr_step_2, e.instr);
    chk("opcode", {26'd0, opcode_step_2}, {26'd0, e.instr[31:26]});
    chk("rs", {27'd0, rs}, {27'd0, e.instr[25:21]});
    chk("rt", {27'd0, rt}, {27'd0, e.instr[20:16]});
    chk("rd", {27'd0, rd}, {27'd0, e.instr[15:11]});
    chk("valid", {31'd0, valid_step_2}, {31'd0, e.valid});
    chk("stall_err", {31'd0, stall_err}, {31'd0, e.err});
    if (e.chk_pc) chk("pc_plus4", pc_plus4_step_2, e.pc);
`ifdef IF_ID_STALL_PERF_EN
    chk("perf_stall", perf_stall_cycles, e.ps);
    chk("perf_events", perf_hazard_events, e.he);
`endif
  endtask

  initial begin
    logic [31:0] lw_word;
    lw_word = {OP_LW, 5'd1, 5'd9, 16'h0000};

    // reset for two cycles, then the first load
    step(1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
    chk("reset_opcode", {26'd0, opcode_step_2}, {26'd0, 6'b111111});
    step(1'b0, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
    chk("first_load", instr_step_2, 32'h2008_0005);

    // single-cycle stall on a load
    step(1'b0, lw_word,       32'h8,  1'b0, 1'b0);
    step(1'b0, 32'h0128_5020, 32'hC,  1'b1, 1'b0);
    step(1'b0, 32'h0128_5020, 32'hC,  1'b0, 1'b0);

    // three-cycle stall
    step(1'b0, lw_word,       32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h012A_5820, 32'h14, 1'b1, 1'b0);
    step(1'b0, 32'h012A_5820, 32'h14, 1'b0, 1'b0);

    // flush wins over a simultaneous hazard
    step(1'b0, lw_word,       32'h18, 1'b0, 1'b0);
    step(1'b0, 32'h0800_0040, 32'h1C, 1'b1, 1'b1);
    chk("flush_nop", instr_step_2, 32'hFC00_0000);

    // hazard ignored on an invalid slot
    step(1'b0, 32'h2009_0007, 32'h20, 1'b1, 1'b0);

    // mixed random traffic
    for (int i = 0; i < 12; i++) begin
      step(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0));
    end

    // watchdog: nine stall cycles, flag must survive until reset
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, lw_word,       32'h40, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0022_1820, 32'h44, 1'b1, 1'b0);
    step(1'b0, 32'h0022_1820, 32'h44, 1'b0, 1'b0);
    step(1'b0, 32'h2008_0001, 32'h48, 1'b0, 1'b0);
    chk("err_sticky", {31'd0, stall_err}, 32'd1);
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_stall_reg.md
# if_id_stall_reg

IF/ID pipeline register with hazard-driven stall control, sitting between the fetch stage and the decode stage. It holds the step-2 instruction, decodes the opcode/rs/rt/rd fields that feed the hazard detector, and consumes the detector's `is_hazard` in the same cycle. On a hazard it freezes the PC and this register and tells the ID/EX register to load a bubble. It also tracks consecutive stall cycles and flags a stuck pipeline.

## Interface
Parameters:
- `MAX_STALL`, default 7: consecutive stall cycles tolerated before `stall_err` is set.
- `CNT_W`, default 4: width of the consecutive-stall counter; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `instr_in`, in, 32: instruction from fetch.
- `pc_plus4_in`, in, 32: PC+4 from fetch.
- `is_hazard`, in, 1: combinational hazard flag computed from this block's step-2 fields.
- `flush`, in, 1: jump/branch redirect; discard the instruction in step 2.
- `instr_step_2`, out, 32: registered instruction.
- `pc_plus4_step_2`, out, 32: registered PC+4.
- `opcode_step_2`, out, 6: `instr_step_2[31:26]`.
- `rs`, out, 5: `instr_step_2[25:21]`.
- `rt`, out, 5: `instr_step_2[20:16]`.
- `rd`, out, 5: `instr_step_2[15:11]`.
- `valid_step_2`, out, 1: step 2 holds a real instruction.
- `pc_we`, out, 1: PC write enable to fetch.
- `bubble_step_3`, out, 1: ID/EX must load a bubble at the next edge.
- `stall_err`, out, 1: sticky watchdog flag.

## Operation
- States: RUN and STALL. STALL is entered when a hazard is active for a valid instruction and `flush` = 0.
- Define `stall_now = is_hazard & valid_step_2 & ~flush`.
  - `pc_we = ~stall_now`.
  - `bubble_step_3 = stall_now | flush | ~valid_step_2`.
- Register update at each edge, highest priority first:
  - `rst`: load `NOP_INSTR`; `valid_step_2` = 0; counter = 0; `stall_err` = 0; state = RUN.
  - `flush`: load `NOP_INSTR`; `valid_step_2` = 0; state = RUN; counter = 0. This applies even if `is_hazard` = 1, because the flushed instruction needs no stall.
  - `stall_now`: hold all contents; state = STALL; counter increments, saturating at 2^CNT_W−1.
  - Otherwise: load `instr_in` and `pc_plus4_in`; `valid_step_2` = 1; state = RUN; counter = 0.
- `NOP_INSTR` = `32'hFC00_0000` (opcode 6'b111111).
  - It must not decode as addi (001000), lw (100011), R-type (000000) or j (000010).
  - This guarantees a bubble never registers as a writer in the downstream hazard compare. An all-zero word would decode as R-type writing r0, which is why it is not used.
- `is_hazard` is ignored when `valid_step_2` = 0.
- Watchdog: when the counter reaches `MAX_STALL` + 1 (stall continuing past `MAX_STALL` cycles), `stall_err` is set. It stays set until `rst`.

## Timing
- Field outputs come straight from the register: zero latency after the edge.
- `pc_we` and `bubble_step_3` are combinational from `is_hazard`/`flush` within the same cycle. There is no registered path in the hazard loop.
- A 1-cycle hazard gives exactly one hold cycle and one bubble. Consecutive hazards with the same step-2 instruction give one bubble per cycle.
- A hazard that drops at cycle N means the register loads `instr_in` at the end of cycle N.
- Reset values:
  - `instr_step_2` = `NOP_INSTR`, `pc_plus4_step_2` = 0, `valid_step_2` = 0.
  - `pc_we` = 1 and `bubble_step_3` = 1 during and after reset until the first load.
  - `stall_err` = 0.
- `rst` asserted mid-stall aborts the stall on that edge.

## Configuration
- `IF_ID_STALL_PERF_EN`
  - Defined: adds two 32-bit wrapping counters, `perf_stall_cycles` (out, 32, +1 per `stall_now` cycle) and `perf_hazard_events` (out, 32, +1 on each RUN→STALL transition). Both are cleared by `rst`.
  - Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode constants `OP_RTYPE`, `OP_ADDI`, `OP_LW`, `OP_J`, `OP_NOP`.
  - `NOP_INSTR`.
  - The RUN/STALL state enum.
- One sub-module, `stall_watchdog`: the saturating consecutive-stall counter plus the sticky `stall_err`. It takes `clk`, `rst`, `stall_now` and `clear` (= ~stall_now).

## Test plan
- **Reset:** `rst` = 1 for 2 cycles, then release with `instr_in` = `32'h2008_0005` → during reset `opcode_step_2` = 6'b111111, `valid_step_2` = 0, `pc_we` = 1; one edge after release `instr_step_2` = `32'h2008_0005`.
- **Single stall:** load lw, hold `is_hazard` = 1 for 1 cycle → `pc_we` = 0 and `bubble_step_3` = 1 for that cycle; `instr_step_2` is unchanged; the next `instr_in` loads at the following edge.
- **Three-cycle stall:** `is_hazard` = 1 for 3 cycles → exactly 3 bubbles, counter reaches 3, `stall_err` = 0; with `IF_ID_STALL_PERF_EN`, `perf_stall_cycles` = 3 and `perf_hazard_events` = 1.
- **Flush vs hazard:** `flush` = 1 and `is_hazard` = 1 in the same cycle → `pc_we` = 1; next cycle `instr_step_2` = `32'hFC00_0000` and `valid_step_2` = 0.
- **Watchdog:** `is_hazard` = 1 for 9 cycles with `MAX_STALL` = 7 → `stall_err` rises after the 8th stall edge and stays 1 after the hazard drops, until `rst`.
- **Bubble ignore:** `valid_step_2` = 0 and `is_hazard` = 1 → `pc_we` = 1, the register loads `instr_in`, and the counter stays 0.
